// File: rtl/data_mem_pkg.sv
// Shared load/store definitions for the data memory slice.
package data_mem_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Clear sequencer states
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_load_ext.sv
// Load lane select plus sign/zero extension; illegal funct3 yields zero.
module mem_load_ext
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            lane,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword (little-endian)
    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Extend according to access type
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_H:    data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable RV32I data memory with a reset-triggered clear sequencer.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misaligned,
    output logic                  busy
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_e         state_q, state_d;
    logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic           clr_we;

    logic [AW-1:0]         widx;
    logic [1:0]            lane;
    logic                  ready;
    logic                  is_b, is_h, is_w, legal;
    logic                  mis;
    logic                  st_we;
    logic [NB-1:0]         st_be;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  addr_unused;

    assign widx        = addr[AW+1:2];
    assign lane        = addr[1:0];
    assign addr_unused = ^addr[DATA_WIDTH-1:AW+2];
    assign ready       = (state_q == ST_READY);
    assign busy        = ~ready;

    // State and clear-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: sweep one word per edge, leave INIT after the last word
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Access decode and misalignment
    always_comb begin
        is_b  = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h  = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w  = (funct3 == F3_W);
        legal = is_b || is_h || is_w;
        mis   = ready && (mem_read || mem_write) &&
                ((is_h && lane[0]) || (is_w && (lane != 2'b00)));
        st_we = ready && mem_write && legal && !mis;
    end

    assign misaligned = mis;

    // Store byte enables and lane-replicated write data
    always_comb begin
        st_be   = '0;
        st_data = wdata;
        if (is_b) begin
            st_be        = NB'(1) << lane;
            st_data      = {NB{wdata[7:0]}};
        end else if (is_h) begin
            st_be        = lane[1] ? NB'(4'b1100) : NB'(4'b0011);
            st_data      = {(NB/2){wdata[15:0]}};
        end else if (is_w) begin
            st_be        = '1;
            st_data      = wdata;
        end
    end

    // Array writes: clear sweep in INIT, masked stores in READY, nothing under reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (st_we) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (st_be[b]) begin
                        mem[widx][8*b +: 8] <= st_data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rd_word = mem[widx];

    mem_load_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_ext (
        .word   (rd_word),
        .lane   (lane),
        .funct3 (funct3),
        .data   (ext_data)
    );

    // Load data gated by state, request and alignment
    always_comb begin
        rdata = '0;
        if (ready && mem_read && legal && !mis) begin
            rdata = ext_data;
        end
    end

endmodule

// File: doc/data_mem.md
# data_mem

Byte-addressable data memory for the single-cycle RISC-V core; sits directly downstream of the ALU and consumes its `result` as the effective address for loads and stores. It performs RV32I byte, halfword and word accesses with sign or zero extension, and flags misaligned accesses. A reset-triggered clear sequencer zeroes the whole array one word per cycle, and asserts `busy` so the core holds the PC until clearing finishes.

## Interface
- `DATA_WIDTH`, 32, data and address width (only 32 supported)
- `DEPTH_WORDS`, 256, number of 32-bit words; power of two, ≥ 4
- `clk`  in  1  core clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  DATA_WIDTH  byte address, taken from the ALU `result`
- `wdata`  in  DATA_WIDTH  store data (rs2)
- `mem_read`  in  1  load request this cycle
- `mem_write`  in  1  store request this cycle
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `rdata`  out  DATA_WIDTH  extended load data, combinational
- `misaligned`  out  1  current request is misaligned, combinational
- `busy`  out  1  clear sequence in progress; core must stall

## Operation
- States: `INIT` and `READY`.
  - A rising edge with `rst`=1 forces `INIT` with `clr_cnt`=0; no array writes occur while `rst` is held.
  - In `INIT` with `rst`=0, each edge writes 0 to `mem[clr_cnt]` and increments `clr_cnt`.
  - When the edge writes `clr_cnt`=DEPTH_WORDS-1, the FSM moves to `READY`.
  - `READY` persists until the next reset. `rst` asserted mid-`INIT` restarts the count at 0.
- Outputs in `INIT` (including while `rst` is held):
  - `busy`=1, `rdata`=0, `misaligned`=0.
  - `mem_read` and `mem_write` are ignored.
- Addressing: word index = `addr[log2(DEPTH_WORDS)+1:2]`, lane = `addr[1:0]`. Upper address bits are ignored, so addresses alias modulo 4·DEPTH_WORDS.
- Misalignment:
  - `misaligned` = (`mem_read`|`mem_write`) & ((H/HU & `addr[0]`) | (W & `addr[1:0]`≠0)).
  - Byte accesses are never misaligned.
  - A misaligned store writes nothing; a misaligned load returns 0.
- Stores (`mem_write`=1, `READY`, aligned) update only the selected lanes at the edge:
  - SB: lane `addr[1:0]` ← `wdata[7:0]`.
  - SH: lanes {`addr[1]`·2+1, `addr[1]`·2} ← `wdata[15:0]`.
  - SW: all four lanes ← `wdata`.
  - Little-endian.
- Loads (`mem_read`=1) read the current array contents combinationally:
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
  - `rdata`=0 when `mem_read`=0.
- Illegal `funct3` (011, 110, 111): no write, `rdata`=0, `misaligned`=0.
- `mem_read` and `mem_write` in the same cycle: `rdata` shows the pre-store contents; the store commits at the edge.

## Timing
- Load latency is 0 cycles (combinational from `addr`, `funct3` and the array).
- Store latency is 1 edge; a load of the same address in the next cycle returns the new data.
- `busy` is high from the reset edge through exactly DEPTH_WORDS edges after the first edge with `rst`=0. `busy` falls combinationally on entering `READY`.
- No other handshake: requests are single-cycle and are never back-pressured in `READY`.

## Structure
- Shared core package holds:
  - `funct3` load/store constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `INIT`/`READY` state enum;
  - the `DATA_WIDTH` default.
- Sub-module `mem_load_ext`: combinational lane select plus sign/zero extension (inputs: word, `addr[1:0]`, `funct3`). Store lane masking stays in the top level.

## Test plan
- Reset then clear:
  - Stimulus: `rst`=1 for 2 cycles, then 0, DEPTH_WORDS=256.
  - Required: `busy`=1 for exactly 256 edges after release, then 0. Word loads at 0x000 and 0x3FC return 0x00000000.
- Store/load sizes:
  - Stimulus: SW 0x80FF7F01 to 0x10.
  - Required: LB 0x10 → 0x00000001; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80FF; LHU 0x12 → 0x000080FF.
- Partial stores:
  - Stimulus: SW 0 to 0x20; SB 0xAB to 0x22; SH 0x1234 to 0x20.
  - Required: LW 0x20 → 0x00AB1234.
- Misalignment:
  - Stimulus: SW to 0x21, then SH to 0x23.
  - Required: `misaligned`=1 for each, with no array change (LW 0x20 unchanged). LW 0x22 → `misaligned`=1, `rdata`=0.
- Simultaneous events and aliasing:
  - Stimulus: same-cycle read+write of 0x30.
  - Required: `rdata` returns the old value, and the new value appears in the next cycle. SW to 0x400 (DEPTH_WORDS=256) is visible at 0x000.
- Reset mid-INIT:
  - Stimulus: assert `rst` at clear count 100, after storing nothing.
  - Required: the count restarts, and `busy` stays high for a full 256 edges after release.
